// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with single outstanding read and static branch prediction
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          PREDICT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stall_i,
    input  logic        branch_error_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        predict_result_o,
    output logic [31:0] next_pc_o,
    output logic        if_stall_req_o
);

    localparam logic [1:0] STALL_PASS = 2'b00;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_VALID,
        S_FLUSH
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        mem_req_nxt;
    logic [31:0] mem_addr_nxt;
    logic        buf_load;
    logic [31:0] buf_inst;
    logic        buf_taken;
    logic [31:0] buf_next;
    logic        pred_taken;
    logic [31:0] pred_next;
    logic [31:0] j_imm;
    logic [31:0] b_imm;

    // Static prediction on the word arriving from memory; pc still holds its fetch address here
    always_comb begin
        j_imm      = {{12{mem_inst_i[31]}}, mem_inst_i[19:12], mem_inst_i[20], mem_inst_i[30:21], 1'b0};
        b_imm      = {{20{mem_inst_i[31]}}, mem_inst_i[7], mem_inst_i[30:25], mem_inst_i[11:8], 1'b0};
        pred_taken = 1'b0;
        pred_next  = pc + 32'd4;
        if (PREDICT_EN) begin
            if (mem_inst_i[6:0] == OPC_JAL) begin
                pred_taken = 1'b1;
                pred_next  = pc + j_imm;
            end else if (mem_inst_i[6:0] == OPC_BRANCH && mem_inst_i[31]) begin
                pred_taken = 1'b1;
                pred_next  = pc + b_imm;
            end
        end
    end

    // Next-state logic; a branch error overrides everything else in every state
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        mem_req_nxt  = mem_req_o;
        mem_addr_nxt = mem_addr_o;
        buf_load     = 1'b0;
        if (branch_error_i) begin
            pc_nxt = branch_target_i;
            case (state)
                S_IDLE: state_nxt = S_IDLE;
                S_WAIT, S_FLUSH: begin
                    if (mem_done_i) begin
                        // in-flight read just finished: drop it and go straight to the target
                        state_nxt    = S_WAIT;
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = branch_target_i;
                    end else begin
                        // read still pending: address must stay put, discard its data later
                        state_nxt = S_FLUSH;
                    end
                end
                S_VALID: begin
                    state_nxt    = S_WAIT;
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = branch_target_i;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt    = S_WAIT;
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = pc;
                end
                S_WAIT: begin
                    if (mem_done_i) begin
                        state_nxt   = S_VALID;
                        mem_req_nxt = 1'b0;
                        buf_load    = 1'b1;
                    end
                end
                S_VALID: begin
                    if (stall_i == STALL_PASS) begin
                        pc_nxt       = buf_next;
                        state_nxt    = S_WAIT;
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = buf_next;
                    end
                end
                S_FLUSH: begin
                    if (mem_done_i) begin
                        state_nxt    = S_WAIT;
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = pc;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State, PC and memory request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            mem_req_o  <= 1'b0;
            mem_addr_o <= 32'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            mem_req_o  <= mem_req_nxt;
            mem_addr_o <= mem_addr_nxt;
        end
    end

    // Instruction buffer, loaded with the fetched word and its prediction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_inst  <= 32'd0;
            buf_taken <= 1'b0;
            buf_next  <= 32'd0;
        end else if (buf_load) begin
            buf_inst  <= mem_inst_i;
            buf_taken <= pred_taken;
            buf_next  <= pred_next;
        end
    end

    // IF/ID outputs are only non-zero while a valid instruction is presented
    always_comb begin
        pc_o             = 32'd0;
        inst_o           = 32'd0;
        predict_result_o = 1'b0;
        next_pc_o        = 32'd0;
        if_stall_req_o   = 1'b1;
        if (state == S_VALID) begin
            pc_o             = pc;
            inst_o           = buf_inst;
            predict_result_o = buf_taken;
            next_pc_o        = buf_next;
            if_stall_req_o   = 1'b0;
        end
    end

endmodule
